// File: rtl/cpu_pkg.sv
// Shared types and constants for the control unit and its decoder.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 4;
  localparam int OPC_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [OPC_W-1:0]  opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_AND  = 4'h3;
  localparam opcode_t OP_OR   = 4'h4;
  localparam opcode_t OP_XOR  = 4'h5;
  localparam opcode_t OP_SHL  = 4'h6;
  localparam opcode_t OP_SHR  = 4'h7;
  localparam opcode_t OP_SLT  = 4'h8;
  localparam opcode_t OP_SLTU = 4'h9;
  localparam opcode_t OP_EQ   = 4'hA;
  localparam opcode_t OP_JZ   = 4'hB;
  localparam opcode_t OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational opcode classifier for the instruction register.
module instr_decode
  import cpu_pkg::*;
(
  input  word_t   ir,
  output opcode_t alu_op,
  output logic    is_alu,
  output logic    is_jz,
  output logic    is_halt,
  output logic    is_nop,
  output logic    is_illegal
);

  opcode_t opc;
  logic    unused_operands;

  assign opc             = ir[15:12];
  assign unused_operands = ^ir[11:0];

  // Classify the opcode; exactly one class flag is high for any ir.
  always_comb begin
    alu_op     = opc;
    is_alu     = 1'b0;
    is_jz      = 1'b0;
    is_halt    = 1'b0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    if (opc == OP_NOP)                          is_nop     = 1'b1;
    else if (opc >= OP_ADD && opc <= OP_EQ)     is_alu     = 1'b1;
    else if (opc == OP_JZ)                      is_jz      = 1'b1;
    else if (opc == OP_HALT)                    is_halt    = 1'b1;
    else                                        is_illegal = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer.
// All outputs come from registered state and ir, never from instr_valid
// or alu_zero, so an async reset clears every output immediately.
module control_unit
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  output logic     instr_req,
  output word_t    instr_addr,
  input  logic     instr_valid,
  input  word_t    instr_data,
  output reg_idx_t rs1_addr,
  output reg_idx_t rs2_addr,
  output opcode_t  alu_op,
  output logic     alu_enable,
  input  logic     alu_zero,
  output logic     rf_we,
  output reg_idx_t rf_waddr,
  output logic     halted,
  output logic     illegal
);

  state_t  state, state_nxt;
  word_t   pc;
  word_t   ir;
  logic    zero_flag;

  opcode_t dec_op;
  logic    is_alu, is_jz, is_halt, is_nop, is_illegal;

  instr_decode u_dec (
    .ir         (ir),
    .alu_op     (dec_op),
    .is_alu     (is_alu),
    .is_jz      (is_jz),
    .is_halt    (is_halt),
    .is_nop     (is_nop),
    .is_illegal (is_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; FETCH waits indefinitely, HALT is terminal.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_FETCH;
      ST_FETCH:     if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_alu)       state_nxt = ST_EXECUTE;
        else if (is_halt) state_nxt = ST_HALT;
        else              state_nxt = ST_FETCH;
      end
      ST_EXECUTE:   state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: state_nxt = ST_FETCH;
      ST_HALT:      state_nxt = ST_HALT;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: pc, instruction register, zero flag.
  // pc wraps naturally at 16 bits; only ALU ops touch zero_flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:      if (start) pc <= '0;
        ST_FETCH:     if (instr_valid) ir <= instr_data;
        ST_DECODE: begin
          if (is_jz)                   pc <= zero_flag ? {8'h00, ir[7:0]} : pc + 16'd1;
          else if (is_nop || is_illegal) pc <= pc + 16'd1;
        end
        ST_EXECUTE:   zero_flag <= alu_zero;
        ST_WRITEBACK: pc <= pc + 16'd1;
        default:      ;
      endcase
    end
  end

  // Output decode from registered state and ir.
  always_comb begin
    instr_req  = (state == ST_FETCH);
    instr_addr = pc;
    rs1_addr   = ir[7:4];
    rs2_addr   = ir[3:0];
    alu_enable = (state == ST_EXECUTE);
    alu_op     = (state == ST_EXECUTE) ? dec_op : OP_NOP;
    rf_we      = (state == ST_WRITEBACK);
    rf_waddr   = ir[11:8];
    halted     = (state == ST_HALT);
    illegal    = (state == ST_DECODE) && is_illegal;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; outputs sampled on the falling edge.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [3:0]  alu_op;
  logic        alu_enable;
  logic        alu_zero;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        halted;
  logic        illegal;

  int n_chk = 0;
  int n_err = 0;
  int ill_cnt = 0;
  logic rf_mon = 1'b0;
  logic rf_seen = 1'b0;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .alu_op      (alu_op),
    .alu_enable  (alu_enable),
    .alu_zero    (alu_zero),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Illegal-pulse counter and rf_we watcher.
  always @(posedge clk) begin
    if (illegal) ill_cnt <= ill_cnt + 1;
    if (rf_mon && rf_we) rf_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a fetch request, hold off 'delay' cycles, then
  // present the word for one cycle. Returns at the falling edge in DECODE.
  task automatic fetch_instr(input logic [15:0] data, input int delay);
    int n = 0;
    logic [15:0] addr0;
    while (!instr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", 32'(instr_req), 32'h1);
    addr0 = instr_addr;
    repeat (delay) begin
      @(negedge clk);
      chk("req_hold", 32'(instr_req), 32'h1);
      chk("addr_hold", 32'(instr_addr), 32'(addr0));
    end
    instr_valid = 1'b1;
    instr_data  = data;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
    chk("dec_req", 32'(instr_req), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0;
    instr_data = 16'h0000; alu_zero = 1'b0;

    // reset state
    #12;
    chk("rst_req",    32'(instr_req),  32'h0);
    chk("rst_addr",   32'(instr_addr), 32'h0);
    chk("rst_alu_en", 32'(alu_enable), 32'h0);
    chk("rst_rf_we",  32'(rf_we),      32'h0);
    chk("rst_halt",   32'(halted),     32'h0);
    chk("rst_ill",    32'(illegal),    32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(instr_req), 32'h0);

    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_req",  32'(instr_req),  32'h1);
    chk("start_addr", 32'(instr_addr), 32'h0);

    // ADD r3 <- r1, r2 with valid one cycle after req
    @(negedge clk);
    fetch_instr(16'h1312, 0);
    chk("dec_alu_en", 32'(alu_enable), 32'h0);
    chk("dec_alu_op", 32'(alu_op),     32'h0);
    @(negedge clk);
    chk("ex_alu_op", 32'(alu_op),     32'h1);
    chk("ex_alu_en", 32'(alu_enable), 32'h1);
    chk("ex_rs1",    32'(rs1_addr),   32'h1);
    chk("ex_rs2",    32'(rs2_addr),   32'h2);
    chk("ex_rf_we",  32'(rf_we),      32'h0);
    @(negedge clk);
    chk("wb_rf_we",  32'(rf_we),      32'h1);
    chk("wb_waddr",  32'(rf_waddr),   32'h3);
    chk("wb_alu_en", 32'(alu_enable), 32'h0);
    @(negedge clk);
    chk("f1_addr",  32'(instr_addr), 32'h1);
    chk("f1_rf_we", 32'(rf_we),      32'h0);

    // NOP with a 5-cycle late valid
    fetch_instr(16'h0000, 5);
    @(negedge clk);
    chk("nop_addr", 32'(instr_addr), 32'h2);

    // SUB with alu_zero=1, NOP keeps the flag, JZ taken
    fetch_instr(16'h2456, 0);
    @(negedge clk);
    chk("sub_op", 32'(alu_op), 32'h2);
    alu_zero = 1'b1;
    @(negedge clk);
    alu_zero = 1'b0;
    @(negedge clk);
    chk("sub_addr", 32'(instr_addr), 32'h3);
    fetch_instr(16'h0000, 0);
    @(negedge clk);
    fetch_instr(16'hB040, 0);
    @(negedge clk);
    chk("jz_taken", 32'(instr_addr), 32'h40);

    // SUB with alu_zero=0, JZ not taken
    fetch_instr(16'h2000, 0);
    @(negedge clk); alu_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sub2_addr", 32'(instr_addr), 32'h41);
    fetch_instr(16'hB040, 0);
    @(negedge clk);
    chk("jz_fall", 32'(instr_addr), 32'h42);

    // illegal opcode then HALT
    ill_cnt = 0;
    fetch_instr(16'hC000, 0);
    chk("ill_pulse", 32'(illegal), 32'h1);
    @(negedge clk);
    chk("ill_drop", 32'(illegal),    32'h0);
    chk("ill_addr", 32'(instr_addr), 32'h43);
    fetch_instr(16'hF000, 0);
    chk("halt_dec", 32'(halted), 32'h0);
    @(negedge clk);
    chk("halted", 32'(halted),    32'h1);
    chk("halt_req", 32'(instr_req), 32'h0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("halt_stay", 32'(halted),    32'h1);
      chk("halt_noreq", 32'(instr_req), 32'h0);
    end
    chk("ill_count", 32'(ill_cnt), 32'h1);

    // reset in the middle of EXECUTE
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("rst2_halt", 32'(halted), 32'h0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    fetch_instr(16'h3123, 0);
    @(negedge clk);
    chk("ex2_en", 32'(alu_enable), 32'h1);
    rf_mon = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_en",  32'(alu_enable), 32'h0);
    chk("rstx_op",  32'(alu_op),     32'h0);
    chk("rstx_req", 32'(instr_req),  32'h0);
    chk("rstx_rs1", 32'(rs1_addr),   32'h0);
    instr_valid = 1'b1; instr_data = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1; instr_data = 16'h5ABC;
    @(negedge clk);
    instr_valid = 1'b0; instr_data = 16'h0000;
    @(negedge clk);
    chk("stale_rs1", 32'(rs1_addr),  32'h0);
    chk("stale_rs2", 32'(rs2_addr),  32'h0);
    chk("stale_req", 32'(instr_req), 32'h0);
    chk("rf_never",  32'(rf_seen),   32'h0);
    rf_mon = 1'b0;

    // pc wrap: park pc at FFFF while fetching, then a NOP
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("wrap_req", 32'(instr_req), 32'h1);
    force dut.pc = 16'hFFFF;
    #1 release dut.pc;
    #1;
    chk("wrap_pre", 32'(instr_addr), 32'hFFFF);
    @(negedge clk);
    fetch_instr(16'h0000, 0);
    @(negedge clk);
    chk("wrap_addr", 32'(instr_addr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
